// File: rtl/rod_motion_ctrl_if.sv
// Rod sprite bus: VGA scan position and game request in, ROM address,
// hit flag and rod status out. The VGA/game side is the master; the rod
// sequencer is the slave.
interface rod_motion_ctrl_if #(
   parameter int ADDR_W = 10
);
   logic [9:0]        DrawX;
   logic [9:0]        DrawY;
   logic              blank;
   logic              activate;
   logic [ADDR_W-1:0] rom_address;
   logic              in_rod;
   logic [9:0]        rod_y;
   logic              moving;
   logic              at_bottom;

   modport master (
      output DrawX, DrawY, blank, activate,
      input  rom_address, in_rod, rod_y, moving, at_bottom
   );

   modport slave (
      input  DrawX, DrawY, blank, activate,
      output rom_address, in_rod, rod_y, moving, at_bottom
   );
endinterface

// File: rtl/rod_motion_ctrl.sv
// Rod motion controller: steps one 64x10 rod sprite between a raised and a
// lowered rest row once per frame, and generates the sprite ROM address and
// a registered in-sprite flag for the palette renderer.
// Optional build macro ROD_TOGGLE_EN: activate becomes edge-triggered and
// each rising edge (at most one per frame) flips the rod's travel target.
module rod_motion_ctrl #(
   parameter int ROD_X  = 18,
   parameter int ROD_W  = 64,
   parameter int ROD_H  = 10,
   parameter int Y_TOP  = 258,
   parameter int Y_BOT  = 318,
   parameter int STEP   = 1,
   parameter int ADDR_W = 10
) (
   input  logic             vga_clk,
   input  logic             reset,
   rod_motion_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_UP,
      ST_LOWERING,
      ST_DOWN,
      ST_RAISING
   } state_t;

   // 11-bit constants so window and clamp compares never wrap.
   localparam logic [10:0] X_LO   = 11'(ROD_X);
   localparam logic [10:0] X_HI   = 11'(ROD_X + ROD_W);
   localparam logic [10:0] H_W    = 11'(ROD_H);
   localparam logic [10:0] STEP_W = 11'(STEP);
   localparam logic [10:0] TOP_W  = 11'(Y_TOP);
   localparam logic [10:0] BOT_W  = 11'(Y_BOT);

   state_t            state_q;
   logic [9:0]        rod_y_q;
   logic              moving_q;
   logic              at_bottom_q;
   logic              in_rod_q;
   logic              frame_tick_q;

   logic [10:0]       draw_x;
   logic [10:0]       draw_y;
   logic [10:0]       rod_y_w;
   logic              hit;
   logic              go_down;
   logic              lower_clamp;
   logic              raise_clamp;
   logic [ADDR_W-1:0] rom_addr_d;

   assign draw_x  = {1'b0, bus.DrawX};
   assign draw_y  = {1'b0, bus.DrawY};
   assign rod_y_w = {1'b0, rod_y_q};

   // Half-open window: last column/row inside, one past it outside.
   assign hit = (draw_x >= X_LO) && (draw_x < X_HI) &&
                (draw_y >= rod_y_w) && (draw_y < rod_y_w + H_W);

   // Raise clamp is phrased as rod_y <= Y_TOP+STEP so rod_y-STEP never underflows.
   assign lower_clamp = (rod_y_w + STEP_W) >= BOT_W;
   assign raise_clamp = rod_y_w <= (TOP_W + STEP_W);

   // Sprite ROM address, row-major with ROD_W pitch; zero outside the sprite.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      rom_addr_d = '0;
      if (hit) begin
         rom_addr_d = ADDR_W'(draw_x - X_LO) +
                      ADDR_W'(draw_y - rod_y_w) * ADDR_W'(ROD_W);
      end
   end

   // One-cycle frame tick, the cycle after the first pixel of the first blank line.
   always_ff @(posedge vga_clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= (bus.DrawX == 10'd0) && (bus.DrawY == 10'd480);
      end
   end

`ifdef ROD_TOGGLE_EN
   logic act_q;
   logic toggle_req_q;
   logic act_rise;

   assign act_rise = bus.activate && !act_q;

   // Sticky toggle request: any rising edges in a frame collapse to one flip.
   // An edge landing on the tick cycle itself carries into the next frame.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         act_q        <= 1'b0;
         toggle_req_q <= 1'b0;
      end else begin
         act_q <= bus.activate;
         if (frame_tick_q) begin
            toggle_req_q <= act_rise;
         end else begin
            toggle_req_q <= toggle_req_q || act_rise;
         end
      end
   end

   // Target direction: flip on a pending toggle, otherwise keep the current heading.
   always_comb begin
      go_down = (state_q == ST_LOWERING) || (state_q == ST_DOWN);
      if (toggle_req_q) begin
         go_down = (state_q == ST_UP) || (state_q == ST_RAISING);
      end
   end
`else
   // Level-controlled: the rod heads down for as long as activate is held.
   assign go_down = bus.activate;
`endif

   // Motion FSM; rod_y and status only change on frame ticks so the sprite never tears.
   always_ff @(posedge vga_clk) begin
      // NOTE: synchronous reset clears only control state; there is no memory here to reset.
      if (reset) begin
         state_q     <= ST_UP;
         rod_y_q     <= 10'(Y_TOP);
         moving_q    <= 1'b0;
         at_bottom_q <= 1'b0;
      end else if (frame_tick_q) begin
         case (state_q)
            ST_UP: begin
               if (go_down) begin
                  state_q  <= ST_LOWERING;
                  moving_q <= 1'b1;
               end
            end
            ST_LOWERING: begin
               if (!go_down) begin
                  state_q <= ST_RAISING;
               end else if (lower_clamp) begin
                  state_q     <= ST_DOWN;
                  rod_y_q     <= 10'(Y_BOT);
                  moving_q    <= 1'b0;
                  at_bottom_q <= 1'b1;
               end else begin
                  rod_y_q <= rod_y_q + 10'(STEP);
               end
            end
            ST_DOWN: begin
               if (!go_down) begin
                  state_q     <= ST_RAISING;
                  moving_q    <= 1'b1;
                  at_bottom_q <= 1'b0;
               end
            end
            ST_RAISING: begin
               if (go_down) begin
                  state_q <= ST_LOWERING;
               end else if (raise_clamp) begin
                  state_q  <= ST_UP;
                  rod_y_q  <= 10'(Y_TOP);
                  moving_q <= 1'b0;
               end else begin
                  rod_y_q <= rod_y_q - 10'(STEP);
               end
            end
            default: begin
               state_q     <= ST_UP;
               rod_y_q     <= 10'(Y_TOP);
               moving_q    <= 1'b0;
               at_bottom_q <= 1'b0;
            end
         endcase
      end
   end

   // Hit flag registered to line up with the renderer's registered colour.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         in_rod_q <= 1'b0;
      end else begin
         in_rod_q <= hit && bus.blank;
      end
   end

   assign bus.rom_address = rom_addr_d;
   assign bus.in_rod      = in_rod_q;
   assign bus.rod_y       = rod_y_q;
   assign bus.moving      = moving_q;
   assign bus.at_bottom   = at_bottom_q;

endmodule

// File: tb/tb_rod_motion_ctrl.sv
// Directed bench for rod_motion_ctrl. Frame ticks are produced by driving
// DrawX/DrawY straight to (0,480) for one cycle instead of scanning a frame.
// Build with ROD_TOGGLE_EN defined to exercise the edge-toggle variant.
module tb_rod_motion_ctrl;

   logic vga_clk = 1'b0;
   logic reset;

   always #5 vga_clk = ~vga_clk;

   rod_motion_ctrl_if #(.ADDR_W(10)) bus ();

   rod_motion_ctrl dut (
      .vga_clk (vga_clk),
      .reset   (reset),
      .bus     (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Pixel vectors: 0..9 with rod_y=258, 10..14 with rod_y=280.
   int px  [15] = '{18, 81, 19, 20, 82, 18, 17, 18, 18, 81,  18,  50,  50,  50,  50};
   int py  [15] = '{258,267,258,260,258,268,258,257,258,258, 280, 285, 279, 290, 289};
   int pb  [15] = '{1,  1,  1,  1,  1,  1,  1,  1,  0,  1,   1,   1,   1,   1,   1};
   int pa  [15] = '{0,  639,1,  130,0,  0,  0,  0,  0,  63,  0,   352, 0,   0,   608};
   int pin [15] = '{1,  1,  1,  1,  0,  0,  0,  0,  0,  1,   1,   1,   0,   0,   1};

   task automatic idle_inputs();
      bus.DrawX = 10'd700;
      bus.DrawY = 10'd100;
      bus.blank = 1'b1;
   endtask

   task automatic apply_reset();
      @(negedge vga_clk);
      idle_inputs();
      reset = 1'b1;
      @(negedge vga_clk);
      reset = 1'b0;
   endtask

   // One frame tick with activate held at act through the tick cycle.
   task automatic do_tick(input logic act);
      @(negedge vga_clk);
      bus.DrawX    = 10'd0;
      bus.DrawY    = 10'd480;
      bus.activate = act;
      @(negedge vga_clk);
      idle_inputs();
      @(negedge vga_clk);
   endtask

   task automatic pulse_activate();
      @(negedge vga_clk);
      bus.activate = 1'b1;
      @(negedge vga_clk);
      bus.activate = 1'b0;
   endtask

   // Bring the rod from reset down to 258+n (1 tick to start, n ticks of motion).
   task automatic lower_by(input int n);
`ifdef ROD_TOGGLE_EN
      pulse_activate();
      do_tick(1'b0);
      for (int k = 0; k < n; k++) do_tick(1'b0);
`else
      do_tick(1'b1);
      for (int k = 0; k < n; k++) do_tick(1'b1);
`endif
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (bus.rod_y !== 10'd258) begin
         errors++; $display("FAIL reset_rod_y got %0d want 258", bus.rod_y);
      end
      checks++;
      if (bus.moving !== 1'b0 || bus.at_bottom !== 1'b0) begin
         errors++; $display("FAIL reset_status got moving=%b at_bottom=%b want 0 0", bus.moving, bus.at_bottom);
      end
      checks++;
      if (bus.in_rod !== 1'b0) begin
         errors++; $display("FAIL reset_in_rod got %b want 0", bus.in_rod);
      end
      for (int f = 0; f < 3; f++) begin
         do_tick(1'b0);
         checks++;
         if (bus.rod_y !== 10'd258 || bus.moving !== 1'b0) begin
            errors++; $display("FAIL idle_frame%0d got rod_y=%0d moving=%b want 258 0", f, bus.rod_y, bus.moving);
         end
      end
   endtask

   task automatic test_hit();
      apply_reset();
      for (int i = 0; i < 15; i++) begin
         if (i == 10) lower_by(22);
         @(negedge vga_clk);
         bus.DrawX = 10'(px[i]);
         bus.DrawY = 10'(py[i]);
         bus.blank = pb[i][0];
         #1;
         checks++;
         if (bus.rom_address !== 10'(pa[i])) begin
            errors++; $display("FAIL hit_addr(%0d,%0d) got %0d want %0d", px[i], py[i], bus.rom_address, pa[i]);
         end
         @(negedge vga_clk);
         checks++;
         if (bus.in_rod !== pin[i][0]) begin
            errors++; $display("FAIL hit_in_rod(%0d,%0d,blank=%0d) got %b want %0d", px[i], py[i], pb[i], bus.in_rod, pin[i]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      lower_by(42);
      checks++;
      if (bus.rod_y !== 10'd300 || bus.moving !== 1'b1) begin
         errors++; $display("FAIL mid_setup got rod_y=%0d moving=%b want 300 1", bus.rod_y, bus.moving);
      end
      apply_reset();
      checks++;
      if (bus.rod_y !== 10'd258 || bus.moving !== 1'b0 || bus.at_bottom !== 1'b0) begin
         errors++; $display("FAIL mid_reset got rod_y=%0d moving=%b at_bottom=%b want 258 0 0", bus.rod_y, bus.moving, bus.at_bottom);
      end
      // From UP, the next start tick must leave rod_y at 258.
      lower_by(0);
      checks++;
      if (bus.rod_y !== 10'd258 || bus.moving !== 1'b1) begin
         errors++; $display("FAIL mid_restart got rod_y=%0d moving=%b want 258 1", bus.rod_y, bus.moving);
      end
   endtask

`ifndef ROD_TOGGLE_EN
   task automatic test_lower_full();
      logic [9:0] held;
      apply_reset();
      do_tick(1'b1);
      checks++;
      if (bus.rod_y !== 10'd258 || bus.moving !== 1'b1 || bus.at_bottom !== 1'b0) begin
         errors++; $display("FAIL lower_tick1 got rod_y=%0d moving=%b at_bottom=%b want 258 1 0", bus.rod_y, bus.moving, bus.at_bottom);
      end
      for (int k = 2; k <= 61; k++) begin
         do_tick(1'b1);
         checks++;
         if (bus.rod_y !== 10'(257 + k) || bus.moving !== (k < 61) || bus.at_bottom !== (k == 61)) begin
            errors++; $display("FAIL lower_tick%0d got rod_y=%0d moving=%b at_bottom=%b want %0d %0d %0d",
                               k, bus.rod_y, bus.moving, bus.at_bottom, 257 + k, k < 61, k == 61);
         end
         if (k == 10) begin
            // activate chatter between ticks must not move the rod
            held = bus.rod_y;
            for (int c = 0; c < 6; c++) begin
               @(negedge vga_clk);
               bus.activate = c[0];
            end
            @(negedge vga_clk);
            checks++;
            if (bus.rod_y !== held || held !== 10'd267) begin
               errors++; $display("FAIL between_ticks got rod_y=%0d want 267", bus.rod_y);
            end
         end
      end
      do_tick(1'b1);
      checks++;
      if (bus.rod_y !== 10'd318 || bus.at_bottom !== 1'b1) begin
         errors++; $display("FAIL down_hold got rod_y=%0d at_bottom=%b want 318 1", bus.rod_y, bus.at_bottom);
      end
      do_tick(1'b0);
      checks++;
      if (bus.rod_y !== 10'd318 || bus.moving !== 1'b1 || bus.at_bottom !== 1'b0) begin
         errors++; $display("FAIL down_release got rod_y=%0d moving=%b at_bottom=%b want 318 1 0", bus.rod_y, bus.moving, bus.at_bottom);
      end
      do_tick(1'b1);
      do_tick(1'b1);
      checks++;
      if (bus.rod_y !== 10'd318 || bus.moving !== 1'b0 || bus.at_bottom !== 1'b1) begin
         errors++; $display("FAIL down_reenter got rod_y=%0d moving=%b at_bottom=%b want 318 0 1", bus.rod_y, bus.moving, bus.at_bottom);
      end
   endtask

   task automatic test_partial_raise();
      apply_reset();
      lower_by(22);
      do_tick(1'b0);
      checks++;
      if (bus.rod_y !== 10'd280 || bus.moving !== 1'b1) begin
         errors++; $display("FAIL raise_enter got rod_y=%0d moving=%b want 280 1", bus.rod_y, bus.moving);
      end
      for (int j = 1; j <= 22; j++) begin
         do_tick(1'b0);
         checks++;
         if (bus.rod_y !== 10'(280 - j) || bus.moving !== (j < 22) || bus.at_bottom !== 1'b0) begin
            errors++; $display("FAIL raise_tick%0d got rod_y=%0d moving=%b want %0d %0d", j, bus.rod_y, bus.moving, 280 - j, j < 22);
         end
      end
   endtask
`else
   task automatic test_toggle();
      apply_reset();
      bus.activate = 1'b0;
      pulse_activate();
      do_tick(1'b0);
      checks++;
      if (bus.rod_y !== 10'd258 || bus.moving !== 1'b1) begin
         errors++; $display("FAIL tog_start got rod_y=%0d moving=%b want 258 1", bus.rod_y, bus.moving);
      end
      for (int k = 2; k <= 61; k++) begin
         do_tick(1'b0);
         checks++;
         if (bus.rod_y !== 10'(257 + k) || bus.at_bottom !== (k == 61)) begin
            errors++; $display("FAIL tog_lower%0d got rod_y=%0d at_bottom=%b want %0d %0d", k, bus.rod_y, bus.at_bottom, 257 + k, k == 61);
         end
      end
      do_tick(1'b0);
      checks++;
      if (bus.rod_y !== 10'd318 || bus.at_bottom !== 1'b1) begin
         errors++; $display("FAIL tog_hold got rod_y=%0d at_bottom=%b want 318 1", bus.rod_y, bus.at_bottom);
      end
      apply_reset();
      lower_by(32);
      checks++;
      if (bus.rod_y !== 10'd290) begin
         errors++; $display("FAIL tog_setup got rod_y=%0d want 290", bus.rod_y);
      end
      pulse_activate();
      do_tick(1'b0);
      checks++;
      if (bus.rod_y !== 10'd290 || bus.moving !== 1'b1) begin
         errors++; $display("FAIL tog_flip got rod_y=%0d moving=%b want 290 1", bus.rod_y, bus.moving);
      end
      do_tick(1'b0);
      checks++;
      if (bus.rod_y !== 10'd289) begin
         errors++; $display("FAIL tog_raise got rod_y=%0d want 289", bus.rod_y);
      end
      pulse_activate();
      pulse_activate();
      do_tick(1'b0);
      do_tick(1'b0);
      do_tick(1'b0);
      checks++;
      if (bus.rod_y !== 10'd291 || bus.moving !== 1'b1) begin
         errors++; $display("FAIL tog_double got rod_y=%0d moving=%b want 291 1", bus.rod_y, bus.moving);
      end
   endtask
`endif

   initial begin
      reset        = 1'b1;
      bus.activate = 1'b0;
      idle_inputs();
      test_reset();
      test_hit();
      test_reset_mid();
`ifndef ROD_TOGGLE_EN
      test_lower_full();
      test_partial_raise();
`else
      test_toggle();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
